flexbus_regbank: RTL and testbench

- Parametrised FlexBus slave register bank; successor to the fixed five-register FlexBus peripheral (LED/buzzer frequency, RGB duty).
- Decodes the multiplexed 32-bit address/data bus and provides NUM_REGS read/write control registers plus NUM_STAT read-only status words.
- Adds programmable wait states, an FB_TA acknowledge, per-register write pulses and full read-back.
- Sits between the MCU FlexBus pins and PL peripherals (PWM, timers, buzzer).

---
 rtl/flexbus_pkg.sv | 43 ++++
 rtl/flexbus_addr_dec.sv | 25 ++
 rtl/flexbus_regbank.sv | 153 +++++++++++++++
 tb/tb_flexbus_regbank.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/flexbus_pkg.sv
// Shared FlexBus slave definitions: word geometry, FSM states, request payload
// and the window hit/index helpers used by the address decoder.
package flexbus_pkg;

    localparam int unsigned FB_WORD_W = 32;
    localparam int unsigned ADDR_LSB  = 2;
    localparam int unsigned WIDX_W    = FB_WORD_W - ADDR_LSB;
    localparam int unsigned IDX_W     = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_XFER = 2'd2,
        ST_ACK  = 2'd3
    } fb_state_e;

    // Request captured during the address phase
    typedef struct packed {
        logic [FB_WORD_W-1:0] addr;
        logic                 rw;
    } fb_req_t;

    // Word offset of addr inside the window starting at base
    function automatic logic [WIDX_W-1:0] fb_word_idx(
        input logic [FB_WORD_W-1:0] addr,
        input logic [FB_WORD_W-1:0] base
    );
        logic [FB_WORD_W-1:0] off;
        off = addr - base;
        return off[FB_WORD_W-1:ADDR_LSB];
    endfunction

    // Aligned, at or above base, and inside num_words words; no wrap-around
    function automatic logic fb_is_hit(
        input logic [FB_WORD_W-1:0] addr,
        input logic [FB_WORD_W-1:0] base,
        input int unsigned          num_words
    );
        return (addr[ADDR_LSB-1:0] == '0) && (addr >= base) &&
               (FB_WORD_W'(fb_word_idx(addr, base)) < num_words);
    endfunction

endpackage

// File: rtl/flexbus_addr_dec.sv
// Combinational FlexBus window decode: hit, status-range flag and word index.
module flexbus_addr_dec
    import flexbus_pkg::*;
#(
    parameter logic [FB_WORD_W-1:0] BASE     = 32'h6000_0000,
    parameter int unsigned          NUM_REGS = 5,
    parameter int unsigned          NUM_STAT = 2
) (
    input  logic [FB_WORD_W-1:0] addr,
    output logic                 hit_c,
    output logic                 is_stat_c,
    output logic [IDX_W-1:0]     idx_c
);

    logic [WIDX_W-1:0] widx;

    // Window decode; is_stat_c only meaningful together with hit_c
    always_comb begin
        widx      = fb_word_idx(addr, BASE);
        hit_c     = fb_is_hit(addr, BASE, NUM_REGS + NUM_STAT);
        is_stat_c = hit_c && (FB_WORD_W'(widx) >= NUM_REGS);
        idx_c     = IDX_W'(widx);
    end

endmodule

// File: rtl/flexbus_regbank.sv
// FlexBus slave register bank: NUM_REGS R/W control registers with write
// pulses, NUM_STAT read-only status words, programmable wait states and FB_TA.
module flexbus_regbank
    import flexbus_pkg::*;
#(
    parameter logic [FB_WORD_W-1:0] FB_BASE     = 32'h6000_0000,
    parameter int unsigned          NUM_REGS    = 5,
    parameter int unsigned          NUM_STAT    = 2,
    parameter int unsigned          WAIT_STATES = 0,
    parameter logic [FB_WORD_W-1:0] RST_VAL     = '0,
    // A status-free bank keeps one unused status word so the port stays legal
    localparam int unsigned         STAT_WORDS  = (NUM_STAT == 0) ? 1 : NUM_STAT
) (
    input  logic                             FB_CLK,
    input  logic                             RST,
    input  logic                             FB_ALE,
    input  logic                             FB_CS,
    input  logic                             FB_RW,
    inout  wire  [FB_WORD_W-1:0]             FB_AD,
    output logic                             FB_TA,
    output logic [FB_WORD_W*NUM_REGS-1:0]    REG_Qout,
    output logic [NUM_REGS-1:0]              REG_WR_Pulse,
    input  logic [FB_WORD_W*STAT_WORDS-1:0]  STAT_Din
);

    localparam int unsigned CNT_W = 4;

    fb_state_e               state_q, state_d;
    fb_req_t                 req_q, req_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    cs_seen_q, cs_seen_d;
    logic [FB_WORD_W-1:0]    rd_buf_q, rd_buf_d;
    logic [FB_WORD_W-1:0]    regs_q [NUM_REGS];
    logic [FB_WORD_W-1:0]    regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]     wr_pulse_q, wr_pulse_d;
    logic                    ta_q, ta_d;

    logic                    hit_c;
    logic                    is_stat_c;
    logic [IDX_W-1:0]        idx_c;
    logic [FB_WORD_W-1:0]    rd_word_c;
    logic                    ad_oe_c;

    flexbus_addr_dec #(
        .BASE     (FB_BASE),
        .NUM_REGS (NUM_REGS),
        .NUM_STAT (NUM_STAT)
    ) u_addr_dec (
        .addr      (req_q.addr),
        .hit_c     (hit_c),
        .is_stat_c (is_stat_c),
        .idx_c     (idx_c)
    );

    // Read-back mux over control registers followed by status words
    always_comb begin
        rd_word_c = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx_c == IDX_W'(i)) rd_word_c = regs_q[i];
        end
        for (int i = 0; i < NUM_STAT; i++) begin
            if (idx_c == IDX_W'(NUM_REGS + i)) rd_word_c = STAT_Din[FB_WORD_W*i +: FB_WORD_W];
        end
    end

    // Bus FSM; ALE restarts a transaction from any state
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        cnt_d      = cnt_q;
        cs_seen_d  = cs_seen_q;
        rd_buf_d   = rd_buf_q;
        regs_d     = regs_q;
        wr_pulse_d = '0;
        ta_d       = 1'b1;

        if (FB_ALE) begin
            req_d.addr = FB_AD;
            req_d.rw   = FB_RW;
            cnt_d      = CNT_W'(WAIT_STATES);
            cs_seen_d  = 1'b0;
            state_d    = ST_WAIT;
        end else begin
            unique case (state_q)
                ST_IDLE: ;
                ST_WAIT: begin
                    if (FB_CS) begin
                        // Idle before the data phase; a CS release after it started abandons the cycle
                        if (cs_seen_q) state_d = ST_IDLE;
                    end else begin
                        cs_seen_d = 1'b1;
                        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
                        else             state_d = ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (hit_c) begin
                        state_d = ST_ACK;
                        ta_d    = 1'b0;
                        if (req_q.rw) begin
                            rd_buf_d = rd_word_c;
                        end else if (!is_stat_c) begin
                            for (int i = 0; i < NUM_REGS; i++) begin
                                if (idx_c == IDX_W'(i)) begin
                                    regs_d[i]     = FB_AD;
                                    wr_pulse_d[i] = 1'b1;
                                end
                            end
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ACK: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and register file, synchronous active-high reset
    always_ff @(posedge FB_CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            req_q      <= '0;
            cnt_q      <= '0;
            cs_seen_q  <= 1'b0;
            rd_buf_q   <= '0;
            wr_pulse_q <= '0;
            ta_q       <= 1'b1;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RST_VAL;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            cnt_q      <= cnt_d;
            cs_seen_q  <= cs_seen_d;
            rd_buf_q   <= rd_buf_d;
            wr_pulse_q <= wr_pulse_d;
            ta_q       <= ta_d;
            regs_q     <= regs_d;
        end
    end

    // Slave drives the bus only in the acknowledge cycle of a selected read
    assign ad_oe_c      = (state_q == ST_ACK) && req_q.rw && !FB_CS;
    assign FB_AD        = ad_oe_c ? rd_buf_q : {FB_WORD_W{1'bz}};
    assign FB_TA        = ta_q;
    assign REG_WR_Pulse = wr_pulse_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_qout
        assign REG_Qout[FB_WORD_W*g +: FB_WORD_W] = regs_q[g];
    end

endmodule

// File: tb/tb_flexbus_regbank.sv
// Directed bench: two banks share one pulled-up bus, one with no wait states
// at 0x6000_0000 and one with three wait states at 0x7000_0000.
module tb_flexbus_regbank;

    logic         clk = 1'b0;
    logic         rst, ale, cs, rw;
    logic         tb_oe;
    logic [31:0]  tb_drv;
    wire  [31:0]  fb_ad;
    logic         ta0, ta1;
    logic [159:0] q0, q1;
    logic [4:0]   p0, p1;
    logic [63:0]  stat;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [159:0] exp0, exp1;

    always #5 clk = ~clk;

    assign fb_ad = tb_oe ? tb_drv : 32'bz;
    for (genvar g = 0; g < 32; g++) begin : g_pu
        pullup (fb_ad[g]);
    end

    flexbus_regbank u_ws0 (
        .FB_CLK(clk), .RST(rst), .FB_ALE(ale), .FB_CS(cs), .FB_RW(rw),
        .FB_AD(fb_ad), .FB_TA(ta0), .REG_Qout(q0), .REG_WR_Pulse(p0), .STAT_Din(stat)
    );

    flexbus_regbank #(.FB_BASE(32'h7000_0000), .WAIT_STATES(3)) u_ws3 (
        .FB_CLK(clk), .RST(rst), .FB_ALE(ale), .FB_CS(cs), .FB_RW(rw),
        .FB_AD(fb_ad), .FB_TA(ta1), .REG_Qout(q1), .REG_WR_Pulse(p1), .STAT_Din(stat)
    );

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Address phase: one ALE edge, then confirm the bus is released
    task automatic addr_phase(input logic [31:0] a, input logic rd, input logic cs_lvl);
        ale = 1'b1; rw = rd; cs = cs_lvl; tb_oe = 1'b1; tb_drv = a;
        #1;
        check("ale_bus", 160'(fb_ad), 160'(a));
        tick();
        ale = 1'b0; tb_oe = 1'b0;
        #1;
        check("ale_rel", 160'(fb_ad), 160'(32'hFFFF_FFFF));
    endtask

    // Data phase: CS low for ncyc edges, recording TA, pulses, read data and stray drive
    task automatic data_phase(input int sel, input logic rd, input logic [31:0] wd, input int ncyc,
                              input logic end_cs, output int ta_cnt, output int ta_first,
                              output int pulse_cnt, output logic [4:0] pulse_val,
                              output logic [31:0] rdata, output int stray);
        logic       t;
        logic [4:0] p;
        ta_cnt = 0; ta_first = 0; pulse_cnt = 0; pulse_val = '0; rdata = 32'hDEAD_DEAD; stray = 0;
        cs = 1'b0; tb_oe = !rd; tb_drv = wd;
        for (int n = 1; n <= ncyc; n++) begin
            tick();
            t = (sel == 1) ? ta1 : ta0;
            p = (sel == 1) ? p1 : p0;
            if (!t) begin
                ta_cnt++;
                if (ta_first == 0) ta_first = n;
                if (rd) rdata = fb_ad;
            end else if (rd && fb_ad !== 32'hFFFF_FFFF) begin
                stray++;
            end
            if (p != '0) begin
                pulse_cnt++;
                pulse_val = p;
            end
        end
        if (end_cs) begin
            cs = 1'b1; tb_oe = 1'b0;
            tick();
        end
    endtask

    int          tc, tf, pc, st;
    logic [4:0]  pv;
    logic [31:0] rdat;
    logic [31:0] miss_addr [3];

    initial begin
        rst = 1'b1; ale = 1'b0; cs = 1'b1; rw = 1'b0; tb_oe = 1'b0; tb_drv = '0;
        stat = {32'h1234_5678, 32'hCAFE_F00D};
        exp0 = '0; exp1 = '0;
        miss_addr[0] = 32'h6000_0002;
        miss_addr[1] = 32'h6000_001C;
        miss_addr[2] = 32'h5FFF_FFFC;
        tick(); tick();
        rst = 1'b0;
        tick();

        check("rst_ta0", 160'(ta0), 160'(1'b1));
        check("rst_ta1", 160'(ta1), 160'(1'b1));
        check("rst_q0", q0, exp0);
        check("rst_q1", q1, exp1);
        check("rst_pulse", 160'({p1, p0}), 160'(0));
        check("rst_bus", 160'(fb_ad), 160'(32'hFFFF_FFFF));

        // Read reg0 after reset, no wait states: ACK entered on the 2nd CS-low edge
        addr_phase(32'h6000_0000, 1'b1, 1'b1);
        data_phase(0, 1'b1, '0, 4, 1'b1, tc, tf, pc, pv, rdat, st);
        check("rd0_data", 160'(rdat), 160'(32'h0));
        check("rd0_ta_cnt", 160'(tc), 160'(1));
        check("rd0_ta_edge", 160'(tf), 160'(2));
        check("rd0_stray", 160'(st), 160'(0));

        // Two writes, one pulse each
        addr_phase(32'h6000_0000, 1'b0, 1'b1);
        data_phase(0, 1'b0, 32'd1000, 4, 1'b1, tc, tf, pc, pv, rdat, st);
        exp0[31:0] = 32'd1000;
        check("wr0_ta_cnt", 160'(tc), 160'(1));
        check("wr0_ta_edge", 160'(tf), 160'(2));
        check("wr0_pulse_cnt", 160'(pc), 160'(1));
        check("wr0_pulse", 160'(pv), 160'(5'b00001));
        check("wr0_q", q0, exp0);

        addr_phase(32'h6000_0004, 1'b0, 1'b1);
        data_phase(0, 1'b0, 32'd2000, 4, 1'b1, tc, tf, pc, pv, rdat, st);
        exp0[63:32] = 32'd2000;
        check("wr1_pulse_cnt", 160'(pc), 160'(1));
        check("wr1_pulse", 160'(pv), 160'(5'b00010));
        check("wr1_q", q0, exp0);

        // Read back
        addr_phase(32'h6000_0000, 1'b1, 1'b1);
        data_phase(0, 1'b1, '0, 4, 1'b1, tc, tf, pc, pv, rdat, st);
        check("rb0_data", 160'(rdat), 160'(32'd1000));
        check("rb0_stray", 160'(st), 160'(0));
        addr_phase(32'h6000_0004, 1'b1, 1'b1);
        data_phase(0, 1'b1, '0, 4, 1'b1, tc, tf, pc, pv, rdat, st);
        check("rb1_data", 160'(rdat), 160'(32'd2000));

        // Three wait states: 4 CS-low edges reach XFER, ACK after the 5th
        addr_phase(32'h7000_0014, 1'b1, 1'b1);
        data_phase(1, 1'b1, '0, 8, 1'b1, tc, tf, pc, pv, rdat, st);
        check("ws3_stat0", 160'(rdat), 160'(32'hCAFE_F00D));
        check("ws3_ta_edge", 160'(tf), 160'(5));
        check("ws3_ta_cnt", 160'(tc), 160'(1));
        check("ws3_stray", 160'(st), 160'(0));
        addr_phase(32'h7000_0018, 1'b1, 1'b1);
        data_phase(1, 1'b1, '0, 8, 1'b1, tc, tf, pc, pv, rdat, st);
        check("ws3_stat1", 160'(rdat), 160'(32'h1234_5678));

        addr_phase(32'h7000_0008, 1'b0, 1'b1);
        data_phase(1, 1'b0, 32'h0000_A5A5, 8, 1'b1, tc, tf, pc, pv, rdat, st);
        exp1[95:64] = 32'h0000_A5A5;
        check("ws3_wr_edge", 160'(tf), 160'(5));
        check("ws3_wr_pulse", 160'(pv), 160'(5'b00100));
        check("ws3_wr_q", q1, exp1);

        // Misaligned, beyond window, below base: silently ignored
        for (int i = 0; i < 3; i++) begin
            addr_phase(miss_addr[i], 1'b0, 1'b1);
            data_phase(0, 1'b0, 32'hDEAD_BEEF, 6, 1'b1, tc, tf, pc, pv, rdat, st);
            check("miss_ta", 160'(tc), 160'(0));
            check("miss_pulse", 160'(pc), 160'(0));
        end
        check("miss_q0", q0, exp0);
        check("miss_q1", q1, exp1);
        addr_phase(32'h6000_001C, 1'b1, 1'b1);
        data_phase(0, 1'b1, '0, 6, 1'b1, tc, tf, pc, pv, rdat, st);
        check("miss_rd_ta", 160'(tc), 160'(0));
        check("miss_rd_stray", 160'(st), 160'(0));

        // Write to a status word: acknowledged, no effect
        addr_phase(32'h6000_0014, 1'b0, 1'b1);
        data_phase(0, 1'b0, 32'h1111_1111, 4, 1'b1, tc, tf, pc, pv, rdat, st);
        check("stwr_ta", 160'(tc), 160'(1));
        check("stwr_pulse", 160'(pc), 160'(0));
        check("stwr_q", q0, exp0);

        // CS released mid-wait abandons the transfer; a later CS-low without ALE does nothing
        addr_phase(32'h7000_000C, 1'b0, 1'b1);
        data_phase(1, 1'b0, 32'h77, 1, 1'b1, tc, tf, pc, pv, rdat, st);
        data_phase(1, 1'b0, 32'h77, 8, 1'b1, tc, tf, pc, pv, rdat, st);
        check("csrise_ta", 160'(tc), 160'(0));
        check("csrise_pulse", 160'(pc), 160'(0));
        check("csrise_q", q1, exp1);

        // New ALE during wait, with CS still low: second address wins
        addr_phase(32'h7000_0000, 1'b0, 1'b1);
        data_phase(1, 1'b0, 32'h0BAD, 2, 1'b0, tc, tf, pc, pv, rdat, st);
        check("realе_first_ta", 160'(tc), 160'(0));
        addr_phase(32'h7000_0004, 1'b0, 1'b0);
        data_phase(1, 1'b0, 32'h55AA, 8, 1'b1, tc, tf, pc, pv, rdat, st);
        exp1[63:32] = 32'h0000_55AA;
        check("reale_ta", 160'(tc), 160'(1));
        check("reale_pulse_cnt", 160'(pc), 160'(1));
        check("reale_pulse", 160'(pv), 160'(5'b00010));
        check("reale_q", q1, exp1);

        // Reset during the wait of a write
        addr_phase(32'h7000_0008, 1'b0, 1'b1);
        data_phase(1, 1'b0, 32'h1234, 1, 1'b0, tc, tf, pc, pv, rdat, st);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstmid_ta", 160'(ta1), 160'(1'b1));
        data_phase(1, 1'b0, 32'h1234, 8, 1'b1, tc, tf, pc, pv, rdat, st);
        exp0 = '0; exp1 = '0;
        check("rstmid_ta_cnt", 160'(tc), 160'(0));
        check("rstmid_pulse", 160'(pc), 160'(0));
        check("rstmid_q0", q0, exp0);
        check("rstmid_q1", q1, exp1);

        // CS held low for 10 edges: a single write
        addr_phase(32'h6000_0010, 1'b0, 1'b1);
        data_phase(0, 1'b0, 32'h0000_0F0F, 10, 1'b1, tc, tf, pc, pv, rdat, st);
        exp0[159:128] = 32'h0000_0F0F;
        check("hold_ta_cnt", 160'(tc), 160'(1));
        check("hold_pulse_cnt", 160'(pc), 160'(1));
        check("hold_pulse", 160'(pv), 160'(5'b10000));
        check("hold_q", q0, exp0);
        addr_phase(32'h6000_0010, 1'b1, 1'b1);
        data_phase(0, 1'b1, '0, 4, 1'b1, tc, tf, pc, pv, rdat, st);
        check("hold_rb", 160'(rdat), 160'(32'h0000_0F0F));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
